fib_stream_gen: RTL and testbench
=================================

# fib_stream_gen

Parametrised Fibonacci term generator with a valid/ready output stream, programmable seeds, overflow-aware end-of-sequence detection and selectable restart/halt behaviour. It is the next generation of the team's fixed 4-bit Fibonacci counter. It sits as a stimulus/pattern source in front of any ready/valid consumer, such as a display driver or a checker. It emits one term per accepted handshake, and never emits a term that does not fit in WIDTH bits.

## Interface
- WIDTH, 8: term width in bits (>=2).
- IDXW, 8: term-index counter width.
- SEED_A, 0: first term after reset.
- SEED_B, 1: second term after reset.
- MODE, 0: 0 = RESTART (reload seeds after last term), 1 = HALT (stop after last term).
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  start/continue request.
- load  in  1  one-cycle pulse; latch seed_a/seed_b as new seeds.
- seed_a  in  WIDTH  first term for load.
- seed_b  in  WIDTH  second term for load.
- saida  out  WIDTH  current term (registered).
- out_valid  out  1  saida holds a term to be consumed.
- out_ready  in  1  consumer accepts; handshake = out_valid & out_ready.
- out_last  out  1  current term is the last representable term.
- term_idx  out  IDXW  index of current term since seed (mod 2^IDXW).
- wrap  out  1  one-cycle pulse: sequence restarted from seeds.
- done  out  1  HALT mode: sequence exhausted.

## Operation
- State registers:
  - cur (drives saida), nxt, nxt_ok.
  - seed registers sa/sb.
  - term_idx.
  - FSM IDLE / RUN / HALT.
- sum = cur + nxt, computed WIDTH+1 bits wide; carry = sum[WIDTH].
- out_last = ~nxt_ok; out_valid = (state == RUN).
- Reset: cur=SEED_A, nxt=SEED_B, sa=SEED_A, sb=SEED_B, nxt_ok=1, term_idx=0, state=IDLE; saida=SEED_A, out_valid=0, out_last=0, wrap=0, done=0.
- IDLE: go to RUN when en=1; no term advance.
- RUN, handshake with out_last=0: cur<=nxt, nxt<=sum[WIDTH-1:0], nxt_ok<=nxt_ok & ~carry, term_idx+1. Stay in RUN if en=1, else go to IDLE.
- RUN, handshake with out_last=1:
  - MODE 0: cur<=sa, nxt<=sb, nxt_ok<=1, term_idx<=0, wrap<=1 for one cycle. Next state RUN if en, else IDLE.
  - MODE 1: state<=HALT, done<=1.
- RUN without handshake: all registers hold. saida and out_valid stay stable regardless of en; en is only acted on at a handshake.
- HALT: out_valid=0, done=1; exit only by rst or load.
- load, which takes priority over any handshake the same cycle:
  - sa/sb and cur/nxt <= seed_a/seed_b; nxt_ok=1, term_idx=0, done=0, wrap=0.
  - state<=IDLE; the in-flight term is discarded.
- Seeds 0,0 give an all-zero stream; out_last is never asserted.
- Seeds whose sum overflows: seed_a emitted with out_last=0, seed_b emitted with out_last=1.
- term_idx wraps modulo 2^IDXW independently of sequence wrap.

## Timing
- All outputs are registered except out_valid and out_last, which decode registered state only. There are no combinational paths from inputs to outputs.
- rst deasserted with en=1 in cycle 0: RUN from cycle 1, first term valid in cycle 1.
- Throughput is 1 term/cycle while out_ready=1; the new term appears the cycle after the handshake edge.
- wrap is high in exactly the cycle in which saida first shows sa after a restart.
- load: the first post-load term is valid 2 cycles after the load cycle, given en=1 (IDLE then RUN).
- rst mid-stream overrides everything, including load, and returns the block to the reset values above on the next edge.

## Test plan
- Basic stream: WIDTH=8, MODE=0, reset seeds, en=1, out_ready=1 -> saida 0,1,1,2,3,5,8,13,21,34,55,89,144,233, with out_last=1 only on 233 (term_idx=13). Next term is 0 with wrap=1 and term_idx=0.
- HALT: WIDTH=4, MODE=1 -> 0,1,1,2,3,5,8,13 with out_last on 13. Then out_valid=0 and done=1 held until load seed_a=2, seed_b=3 -> 2,3,5,8,13 then done again.
- Backpressure: toggle out_ready randomly -> saida stable while out_valid & ~out_ready; no term skipped or repeated versus the reference sequence.
- Pause: drop en mid-stream -> block goes to IDLE after the next handshake, out_valid=0, state preserved. Raise en -> stream resumes with the following term.
- Boundary seeds: WIDTH=8, load 200,100 -> 200 (last=0), then 100 (last=1), then restart at 200 with wrap=1. Load 0,0 -> endless zeros with out_last=0.
- Reset/load collisions: assert load during a handshake -> load wins. Assert rst together with load mid-stream -> reset values on the next edge, out_valid=0.

Source files
------------

// File: rtl/fib_stream_gen.sv
// Fibonacci term source with a ready/valid output stream, loadable seeds and
// overflow-aware end of sequence; restarts from the seeds or halts per MODE.
module fib_stream_gen #(
  parameter int                 WIDTH  = 8,
  parameter int                 IDXW   = 8,
  parameter logic [WIDTH-1:0]   SEED_A = '0,
  parameter logic [WIDTH-1:0]   SEED_B = WIDTH'(1),
  parameter int                 MODE   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic [WIDTH-1:0]  seed_a,
  input  logic [WIDTH-1:0]  seed_b,
  output logic [WIDTH-1:0]  saida,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [IDXW-1:0]   term_idx,
  output logic              wrap,
  output logic              done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_cur, r_nxt, r_sa, r_sb;
  logic             r_nxt_ok;
  logic [IDXW-1:0]  r_idx;
  logic             r_wrap, r_done;

  logic [WIDTH:0]   w_sum;
  logic             w_hs;
  logic             w_last;

  // Once a carry is seen, nxt no longer fits, so cur is the last legal term.
  assign w_sum  = {1'b0, r_cur} + {1'b0, r_nxt};
  assign w_last = ~r_nxt_ok;
  assign w_hs   = (r_state == S_RUN) & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cur    <= SEED_A;
      r_nxt    <= SEED_B;
      r_sa     <= SEED_A;
      r_sb     <= SEED_B;
      r_nxt_ok <= 1'b1;
      r_idx    <= '0;
      r_wrap   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (load) begin
        r_sa     <= seed_a;
        r_sb     <= seed_b;
        r_cur    <= seed_a;
        r_nxt    <= seed_b;
        r_nxt_ok <= 1'b1;
        r_idx    <= '0;
        r_done   <= 1'b0;
        r_state  <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: if (en) r_state <= S_RUN;
          S_RUN: begin
            if (w_hs) begin
              if (!w_last) begin
                r_cur    <= r_nxt;
                r_nxt    <= w_sum[WIDTH-1:0];
                r_nxt_ok <= r_nxt_ok & ~w_sum[WIDTH];
                r_idx    <= r_idx + IDXW'(1);
                r_state  <= en ? S_RUN : S_IDLE;
              end else if (MODE == 0) begin
                r_cur    <= r_sa;
                r_nxt    <= r_sb;
                r_nxt_ok <= 1'b1;
                r_idx    <= '0;
                r_wrap   <= 1'b1;
                r_state  <= en ? S_RUN : S_IDLE;
              end else begin
                r_state  <= S_HALT;
                r_done   <= 1'b1;
              end
            end
          end
          S_HALT: r_state <= S_HALT;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign saida     = r_cur;
  assign out_valid = (r_state == S_RUN);
  assign out_last  = w_last;
  assign term_idx  = r_idx;
  assign wrap      = r_wrap;
  assign done      = r_done;

endmodule

// File: tb/tb_fib_stream_gen.sv
// Scoreboard bench: an 8-bit restart instance and a 4-bit halt instance, each
// checked term by term against an integer Fibonacci model.
module tb_fib_stream_gen;

  typedef struct {
    int val;
    bit last;
    int idx;
    bit wrap;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       en8 = 0, load8 = 0, rdy8 = 0;
  logic [7:0] sa8 = '0, sb8 = '0;
  logic [7:0] saida8, idx8;
  logic       vld8, last8, wrap8, done8;

  logic       en4 = 0, load4 = 0, rdy4 = 0;
  logic [3:0] sa4 = '0, sb4 = '0;
  logic [3:0] saida4;
  logic [7:0] idx4;
  logic       vld4, last4, wrap4, done4;

  int total = 0;
  int bad   = 0;

  exp_t q8[$];
  exp_t q4[$];
  exp_t e8, e4;
  bit   fresh8 = 0, stall8 = 0, fresh4 = 0, stall4 = 0;
  int   hold8 = 0, hold4 = 0;

  always #5 clk = ~clk;

  fib_stream_gen #(.WIDTH(8), .IDXW(8), .MODE(0)) u_dut8 (
    .clk(clk), .rst(rst), .en(en8), .load(load8), .seed_a(sa8), .seed_b(sb8),
    .saida(saida8), .out_valid(vld8), .out_ready(rdy8), .out_last(last8),
    .term_idx(idx8), .wrap(wrap8), .done(done8)
  );

  fib_stream_gen #(.WIDTH(4), .IDXW(8), .MODE(1)) u_dut4 (
    .clk(clk), .rst(rst), .en(en4), .load(load4), .seed_a(sa4), .seed_b(sb4),
    .saida(saida4), .out_valid(vld4), .out_ready(rdy4), .out_last(last4),
    .term_idx(idx4), .wrap(wrap4), .done(done4)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Integer model: term x is last when the following term no longer fits.
  task automatic gen(input int sel, input longint a, input longint b,
                     input int n, input bit halt);
    longint x = a, y = b, t;
    longint lim = longint'(1) << (sel == 4 ? 4 : 8);
    int idx = 0;
    bit wr = 0;
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.val  = int'(x);
      e.last = (y >= lim);
      e.idx  = idx;
      e.wrap = wr;
      if (sel == 4) q4.push_back(e); else q8.push_back(e);
      wr = 0;
      if (e.last) begin
        if (halt) break;
        x = a; y = b; idx = 0; wr = 1;
      end else begin
        t = x + y; x = y; y = t; idx = (idx + 1) % 256;
      end
    end
  endtask

  task automatic drain(input int sel, input int budget, input bit rnd);
    int c = 0;
    if (sel == 4) rdy4 = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    else          rdy8 = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    while (c < budget) begin
      tick();
      c++;
      if ((sel == 4 ? q4.size() : q8.size()) == 0) break;
      if (sel == 4) rdy4 = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      else          rdy8 = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    if (sel == 4) begin rdy4 = 0; chk("drain4", q4.size(), 0); end
    else          begin rdy8 = 0; chk("drain8", q8.size(), 0); end
  endtask

  task automatic rst_pulse();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  always @(negedge clk) begin
    if (!rst && !load8 && vld8 && rdy8) begin
      if (q8.size() == 0) chk("extra8", q8.size(), 1);
      else begin
        e8 = q8.pop_front();
        chk("val8",  int'(saida8), e8.val);
        chk("last8", int'(last8),  int'(e8.last));
        chk("idx8",  int'(idx8),   e8.idx);
        if (fresh8) chk("wrap8", int'(wrap8), int'(e8.wrap));
      end
    end
    if (stall8) chk("hold8", int'(saida8), hold8);
    fresh8 = !rst && !load8 && vld8 && rdy8;
    stall8 = !rst && !load8 && vld8 && !rdy8;
    hold8  = int'(saida8);
  end

  always @(negedge clk) begin
    if (!rst && !load4 && vld4 && rdy4) begin
      if (q4.size() == 0) chk("extra4", q4.size(), 1);
      else begin
        e4 = q4.pop_front();
        chk("val4",  int'(saida4), e4.val);
        chk("last4", int'(last4),  int'(e4.last));
        chk("idx4",  int'(idx4),   e4.idx);
        if (fresh4) chk("wrap4", int'(wrap4), int'(e4.wrap));
      end
    end
    if (stall4) chk("hold4", int'(saida4), hold4);
    fresh4 = !rst && !load4 && vld4 && rdy4;
    stall4 = !rst && !load4 && vld4 && !rdy4;
    hold4  = int'(saida4);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    // reset values
    rst_pulse();
    tick();
    chk("rst_saida", int'(saida8), 0);
    chk("rst_vld",   int'(vld8),   0);
    chk("rst_last",  int'(last8),  0);
    chk("rst_wrap",  int'(wrap8),  0);
    chk("rst_done",  int'(done8),  0);
    chk("rst_idx",   int'(idx8),   0);

    // basic stream through one restart
    gen(8, 0, 1, 16, 0);
    en8 = 1;
    drain(8, 100, 0);

    // random backpressure across two restarts
    q8.delete();
    gen(8, 0, 1, 40, 0);
    rst_pulse();
    tick();
    chk("first_vld", int'(vld8), 1);
    drain(8, 600, 1);

    // pause and resume
    rst_pulse();
    q8.delete();
    gen(8, 0, 1, 10, 0);
    rdy8 = 1;
    repeat (4) tick();
    en8 = 0;
    repeat (3) tick();
    chk("pause_vld", int'(vld8), 0);
    en8 = 1;
    drain(8, 100, 0);

    // load collides with a handshake; overflowing seeds
    q8.delete();
    gen(8, 200, 100, 6, 0);
    sa8 = 8'd200; sb8 = 8'd100; load8 = 1; rdy8 = 1;
    tick();
    load8 = 0;
    chk("load_vld",  int'(vld8),   0);
    chk("load_cur",  int'(saida8), 200);
    chk("load_idx",  int'(idx8),   0);
    tick();
    chk("load_lat",  int'(vld8),   1);
    drain(8, 100, 0);

    // all-zero seeds
    q8.delete();
    gen(8, 0, 0, 20, 0);
    sa8 = 0; sb8 = 0; load8 = 1;
    tick();
    load8 = 0;
    drain(8, 100, 0);

    // reset beats load mid-stream
    sa8 = 8'd77; sb8 = 8'd88; load8 = 1; rst = 1;
    tick();
    chk("rl_saida", int'(saida8), 0);
    chk("rl_vld",   int'(vld8),   0);
    chk("rl_done",  int'(done8),  0);
    rst = 0; load8 = 0;
    q8.delete();
    gen(8, 0, 1, 5, 0);
    drain(8, 100, 0);
    en8 = 0;

    // halt mode
    gen(4, 0, 1, 100, 1);
    en4 = 1;
    drain(4, 100, 0);
    rdy4 = 1;
    repeat (5) tick();
    chk("halt_vld",  int'(vld4),  0);
    chk("halt_done", int'(done4), 1);
    rdy4 = 0;
    gen(4, 2, 3, 100, 1);
    sa4 = 4'd2; sb4 = 4'd3; load4 = 1;
    tick();
    load4 = 0;
    chk("reload_done", int'(done4), 0);
    drain(4, 100, 0);
    rdy4 = 1;
    repeat (4) tick();
    chk("halt2_done", int'(done4), 1);
    chk("halt2_vld",  int'(vld4),  0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
